countdown_timer_ctrl: RTL and testbench

Sequencing controller for the countdown Timer datapath of the clock project. It loads and validates an HH:MM:SS preset, divides clk down to a 1 Hz tick, and decrements with borrow. It runs a start/pause/clear state machine and drives the buzzer for a fixed number of seconds on expiry. Its count outputs feed the LCD_Display timer fields, and its buzzer output replaces the Timer stub.

---
 rtl/countdown_timer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer sequencer: preset load/validate, 1 Hz prescaler, HH:MM:SS borrow decrement,
// start/pause/clear FSM and buzzer hold. Optional macro TIMER_AUTO_RELOAD_EN restarts from the preset after ALARM.
module countdown_timer_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [3:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [2:0] state,
    output logic       running,
    output logic       expired,
    output logic       buzzer,
    output logic       load_err
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(ALARM_SECS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOADED = 3'd1,
        RUN    = 3'd2,
        PAUSE  = 3'd3,
        ALARM  = 3'd4
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [AW-1:0] alarmCnt_q;
    logic [3:0]    presetHours_q, hours_q;
    logic [5:0]    presetMinutes_q, minutes_q;
    logic [5:0]    presetSeconds_q, seconds_q;
    logic          running_q, expired_q, buzzer_q, loadErr_q;

    logic          counting, tick, loadable, loadValid, decZero;
    logic [3:0]    hours_d;
    logic [5:0]    minutes_d, seconds_d;

    assign counting  = (state_q == RUN) || (state_q == ALARM);
    assign tick      = counting && (presc_q == PW'(DIV - 1));
    assign loadable  = (state_q == IDLE) || (state_q == LOADED) || (state_q == PAUSE);
    assign loadValid = (set_minutes <= 6'd59) && (set_seconds <= 6'd59) &&
                       ({set_hours, set_minutes, set_seconds} != 16'd0);

    // One-second decrement with borrow across the three fields
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (seconds_q != 6'd0) begin
            seconds_d = seconds_q - 6'd1;
        end else if (minutes_q != 6'd0) begin
            minutes_d = minutes_q - 6'd1;
            seconds_d = 6'd59;
        end else if (hours_q != 4'd0) begin
            hours_d   = hours_q - 4'd1;
            minutes_d = 6'd59;
            seconds_d = 6'd59;
        end
    end

    assign decZero = ({hours_d, minutes_d, seconds_d} == 16'd0);

    // Commands resolve by priority; a tick only acts when no command took effect this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            presc_q         <= '0;
            alarmCnt_q      <= '0;
            presetHours_q   <= '0;
            presetMinutes_q <= '0;
            presetSeconds_q <= '0;
            hours_q         <= '0;
            minutes_q       <= '0;
            seconds_q       <= '0;
            running_q       <= 1'b0;
            expired_q       <= 1'b0;
            buzzer_q        <= 1'b0;
            loadErr_q       <= 1'b0;
        end else begin
            loadErr_q <= 1'b0;
            if (counting) begin
                presc_q <= tick ? '0 : presc_q + 1'b1;
            end

            if (clear) begin
                state_q    <= IDLE;
                presc_q    <= '0;
                alarmCnt_q <= '0;
                hours_q    <= '0;
                minutes_q  <= '0;
                seconds_q  <= '0;
                running_q  <= 1'b0;
                expired_q  <= 1'b0;
                buzzer_q   <= 1'b0;
            end else if (load && loadable) begin
                if (loadValid) begin
                    state_q         <= LOADED;
                    hours_q         <= set_hours;
                    minutes_q       <= set_minutes;
                    seconds_q       <= set_seconds;
                    presetHours_q   <= set_hours;
                    presetMinutes_q <= set_minutes;
                    presetSeconds_q <= set_seconds;
                    expired_q       <= 1'b0;
                    running_q       <= 1'b0;
                end else begin
                    loadErr_q <= 1'b1;
                end
            end else if (!load && pause && state_q == RUN) begin
                state_q   <= PAUSE;
                running_q <= 1'b0;
            end else if (!load && !pause && start &&
                         (state_q == LOADED || state_q == PAUSE)) begin
                // Resuming from PAUSE keeps the fractional second already counted
                if (state_q == LOADED) begin
                    presc_q <= '0;
                end
                state_q   <= RUN;
                running_q <= 1'b1;
            end else if (tick && state_q == RUN) begin
                hours_q   <= hours_d;
                minutes_q <= minutes_d;
                seconds_q <= seconds_d;
                if (decZero) begin
                    state_q    <= ALARM;
                    running_q  <= 1'b0;
                    expired_q  <= 1'b1;
                    buzzer_q   <= 1'b1;
                    alarmCnt_q <= '0;
                end
            end else if (tick && state_q == ALARM) begin
                if (alarmCnt_q == AW'(ALARM_SECS - 1)) begin
                    alarmCnt_q <= '0;
                    buzzer_q   <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
                    state_q    <= RUN;
                    running_q  <= 1'b1;
                    presc_q    <= '0;
                    hours_q    <= presetHours_q;
                    minutes_q  <= presetMinutes_q;
                    seconds_q  <= presetSeconds_q;
`else
                    state_q    <= IDLE;
`endif
                end else begin
                    alarmCnt_q <= alarmCnt_q + 1'b1;
                end
            end
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign state    = state_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign buzzer   = buzzer_q;
    assign load_err = loadErr_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: a seconds-total reference model predicts every cycle,
// a monitor compares the DUT one step after each rising edge.
module tb_countdown_timer_ctrl;

    localparam int ALARM_N = 2;
    localparam int DIVN    = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [3:0] set_hours = '0;
    logic [5:0] set_minutes = '0, set_seconds = '0;
    logic [3:0] hours;
    logic [5:0] minutes, seconds;
    logic [2:0] state;
    logic       running, expired, buzzer, load_err;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       run;
        logic       exp;
        logic       buz;
        logic       err;
    } snap_t;

    snap_t expQ[$];
    int    checks = 0;
    int    passes = 0;
    int    cycleNo = 0;

    // Reference model: remaining time kept as a plain count of seconds
    int mState = 0, mRem = 0, mPreset = 0, mPhase = 0, mAlarm = 0;
    bit mExp = 0, mErr = 0;

    countdown_timer_ctrl #(.CLK_FREQ(10), .TICK_HZ(1), .ALARM_SECS(ALARM_N)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .start(start), .pause(pause), .clear(clear),
        .set_hours(set_hours), .set_minutes(set_minutes), .set_seconds(set_seconds),
        .hours(hours), .minutes(minutes), .seconds(seconds), .state(state),
        .running(running), .expired(expired), .buzzer(buzzer), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mState = 0; mRem = 0; mPreset = 0; mPhase = 0; mAlarm = 0; mExp = 0; mErr = 0;
    endtask

    task automatic modelStep(input bit ld, input bit st, input bit ps, input bit cl,
                             input int h, input int m, input int s);
        bit tk, acted, cnt;
        cnt   = (mState == 2) || (mState == 4);
        tk    = cnt && (mPhase == DIVN - 1);
        acted = 0;
        mErr  = 0;
        if (cnt) mPhase = tk ? 0 : mPhase + 1;
        if (cl) begin
            mState = 0; mRem = 0; mExp = 0; mPhase = 0; mAlarm = 0; acted = 1;
        end else if (ld) begin
            if (mState == 0 || mState == 1 || mState == 3) begin
                acted = 1;
                if (m <= 59 && s <= 59 && (h * 3600 + m * 60 + s) != 0) begin
                    mRem = h * 3600 + m * 60 + s; mPreset = mRem; mExp = 0; mState = 1;
                end else begin
                    mErr = 1;
                end
            end
        end else if (ps) begin
            if (mState == 2) begin mState = 3; acted = 1; end
        end else if (st) begin
            if (mState == 1) begin mState = 2; mPhase = 0; acted = 1; end
            else if (mState == 3) begin mState = 2; acted = 1; end
        end
        if (!acted && tk) begin
            if (mState == 2) begin
                mRem = mRem - 1;
                if (mRem == 0) begin mState = 4; mExp = 1; mAlarm = 0; end
            end else begin
                mAlarm = mAlarm + 1;
                if (mAlarm == ALARM_N) begin
                    mAlarm = 0;
`ifdef TIMER_AUTO_RELOAD_EN
                    mRem = mPreset; mState = 2; mPhase = 0;
`else
                    mState = 0;
`endif
                end
            end
        end
    endtask

    function automatic snap_t modelSnap();
        snap_t e;
        e.st  = 3'(mState);
        e.h   = 4'(mRem / 3600);
        e.m   = 6'((mRem % 3600) / 60);
        e.s   = 6'(mRem % 60);
        e.run = (mState == 2);
        e.exp = mExp;
        e.buz = (mState == 4);
        e.err = mErr;
        return e;
    endfunction

    task automatic driveAndPush(input bit ld, input bit st, input bit ps, input bit cl,
                                input int h, input int m, input int s);
        load = ld; start = st; pause = ps; clear = cl;
        set_hours = 4'(h); set_minutes = 6'(m); set_seconds = 6'(s);
        modelStep(ld, st, ps, cl, h, m, s);
        expQ.push_back(modelSnap());
    endtask

    task automatic applyStimulus(input bit ld, input bit st, input bit ps, input bit cl,
                                 input int h, input int m, input int s);
        @(negedge clk);
        driveAndPush(ld, st, ps, cl, h, m, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkReset(input string name);
        checks++;
        if (state == 3'd0 && hours == 4'd0 && minutes == 6'd0 && seconds == 6'd0 &&
            !running && !expired && !buzzer && !load_err) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got st=%0d %0d:%0d:%0d run=%0b exp=%0b buz=%0b err=%0b, want all zero",
                     name, state, hours, minutes, seconds, running, expired, buzzer, load_err);
        end
    endtask

    task automatic applyReset(input string name);
        @(negedge clk);
        load = 0; start = 0; pause = 0; clear = 0;
        rst_n = 1'b0;
        #1;
        checkReset(name);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        driveAndPush(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input snap_t e);
        snap_t a;
        a = '{st: state, h: hours, m: minutes, s: seconds,
              run: running, exp: expired, buz: buzzer, err: load_err};
        checks++;
        if (a === e) begin
            passes++;
        end else begin
            $display("[TB] FAIL cycle%0d: got st=%0d %0d:%0d:%0d run=%0b exp=%0b buz=%0b err=%0b, want st=%0d %0d:%0d:%0d run=%0b exp=%0b buz=%0b err=%0b",
                     cycleNo, a.st, a.h, a.m, a.s, a.run, a.exp, a.buz, a.err,
                     e.st, e.h, e.m, e.s, e.run, e.exp, e.buz, e.err);
        end
    endtask

    // Monitor: one expected snapshot per driven edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycleNo++;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int r, h, m, s;
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("initial_reset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // 0:00:03 countdown through expiry and alarm
        applyStimulus(1, 0, 0, 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(60);

        // Borrow across hours, then across minutes
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(12);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(12);

        // Rejected presets leave everything unchanged
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 7);
        applyStimulus(1, 0, 0, 0, 0, 60, 0);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 61);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Pause keeps the fractional second
        applyStimulus(1, 0, 0, 0, 0, 0, 5);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(14);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        idle(100);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(10);

        // Clear beats start; a bare start afterwards does nothing
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        idle(3);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(3);

        // Reset in the middle of ALARM
        applyStimulus(1, 0, 0, 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(25);
        applyReset("reset_mid_alarm");

        // Full expiry with alarm completion (auto-reload path when enabled)
        applyStimulus(1, 0, 0, 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(70);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        // Randomised command stream
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                applyReset("reset_random");
            end else if (r < 40) begin
                if ($urandom_range(0, 1) == 0) begin
                    h = 0; m = 0; s = $urandom_range(1, 6);
                end else begin
                    h = $urandom_range(0, 15); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
                end
                applyStimulus(1, 0, 0, 0, h, m, s);
            end else if (r < 80) begin
                applyStimulus(0, 1, 0, 0, 0, 0, 0);
            end else if (r < 90) begin
                applyStimulus(0, 0, 1, 0, 0, 0, 0);
            end else if (r < 94) begin
                applyStimulus(0, $urandom_range(0, 1), 0, 1, 0, 0, 0);
            end else begin
                applyStimulus(0, 0, 0, 0, 0, 0, 0);
            end
        end

        idle(2);
        @(negedge clk);
        checks++;
        if (expQ.size() == 0) passes++;
        else $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
